// File: rtl/stage2_decode.sv
`default_nettype none
// ============================================================================
// Module   : stage2_decode
// Purpose  : MIPS instruction-decode stage. Holds the 32x32 register file,
//            decodes control fields, resolves BEQ/J in decode, detects
//            load-use hazards and squashes the wrong-path slot after a taken
//            branch/jump. Drives the ID/EX pipeline register.
// Ports    : clk, reset (sync, active-low), En_Pipeline
//            Instruction_in/PC_in        - from fetch
//            WB_en/WB_addr/WB_data       - register-file write-back
//            EX_MemRead/EX_rt            - load in EX (hazard detection)
//            Stall, PC_sel, addr_BR_JMP  - combinational feedback to fetch
//            RD1_out..Valid_out          - registered ID/EX outputs
// Revision : 1.0 - initial release
// ============================================================================
module stage2_decode #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En_Pipeline,
    input  logic [31:0]       Instruction_in,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic              WB_en,
    input  logic [4:0]        WB_addr,
    input  logic [DATA_W-1:0] WB_data,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_rt,
    output logic              Stall,
    output logic              PC_sel,
    output logic [ADDR_W-1:0] addr_BR_JMP,
    output logic [DATA_W-1:0] RD1_out,
    output logic [DATA_W-1:0] RD2_out,
    output logic [DATA_W-1:0] Imm_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [3:0]        ALU_op,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              ALUSrc,
    output logic              RegDst,
    output logic              DSP_sel,
    output logic              Valid_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_DSP   = 6'h3F;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t state;

    logic [DATA_W-1:0] rf [NREG];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign op  = Instruction_in[31:26];
    assign rs  = Instruction_in[25:21];
    assign rt  = Instruction_in[20:16];
    assign rd  = Instruction_in[15:11];
    assign imm = Instruction_in[15:0];

    // Read ports with write-back bypass so a value written this cycle is
    // visible to the instruction decoding in the same cycle.
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    always_comb begin
        rd1 = rf[rs];
        if (rs == 5'd0)
            rd1 = '0;
        else if (WB_en && (WB_addr == rs))
            rd1 = WB_data;

        rd2 = rf[rt];
        if (rt == 5'd0)
            rd2 = '0;
        else if (WB_en && (WB_addr == rt))
            rd2 = WB_data;
    end

    logic is_beq;
    logic is_j;
    logic uses_rt;

    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    // ADDI/LW only write rt, so a pending load into rt is not a hazard for them.
    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || is_beq || (op == OP_DSP);

    logic stall_c;
    logic taken;
    logic [ADDR_W-1:0] target;

    always_comb begin
        stall_c = 1'b0;
        if (reset && (state == NORMAL) && EX_MemRead && (EX_rt != 5'd0) &&
            ((EX_rt == rs) || ((EX_rt == rt) && uses_rt)))
            stall_c = 1'b1;

        taken  = 1'b0;
        target = '0;
        if (reset && (state == NORMAL) && !stall_c) begin
            if (is_beq && (rd1 == rd2)) begin
                taken  = 1'b1;
                target = PC_in + ADDR_W'(1) + ADDR_W'(imm[11:0]);
            end else if (is_j) begin
                taken  = 1'b1;
                target = ADDR_W'(Instruction_in[11:0]);
            end
        end
    end

    assign Stall       = stall_c;
    assign PC_sel      = taken && En_Pipeline;
    assign addr_BR_JMP = PC_sel ? target : '0;

    // Register file: write-back is independent of the pipeline enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (WB_en && (WB_addr != 5'd0)) begin
            rf[WB_addr] <= WB_data;
        end
    end

    // Flush FSM and ID/EX register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= NORMAL;
            RD1_out   <= '0;
            RD2_out   <= '0;
            Imm_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            ALU_op    <= '0;
            RegWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            RegDst    <= 1'b0;
            DSP_sel   <= 1'b0;
            Valid_out <= 1'b0;
        end else if (En_Pipeline) begin
            case (state)
                NORMAL:  state <= PC_sel ? FLUSH : NORMAL;
                FLUSH:   state <= NORMAL;
                default: state <= NORMAL;
            endcase

            // Default every slot to a bubble, then fill in the decoded fields.
            RD1_out   <= '0;
            RD2_out   <= '0;
            Imm_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            ALU_op    <= '0;
            RegWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            RegDst    <= 1'b0;
            DSP_sel   <= 1'b0;
            Valid_out <= 1'b0;

            if (!stall_c && (state == NORMAL) && !is_beq && !is_j) begin
                Valid_out <= 1'b1;
                // Unrecognised opcodes stay an all-zero NOP that is still valid.
                if ((op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
                    (op == OP_SW) || (op == OP_DSP)) begin
                    RD1_out <= rd1;
                    RD2_out <= rd2;
                    Imm_out <= {{(DATA_W-16){imm[15]}}, imm};
                    rs_out  <= rs;
                    rt_out  <= rt;
                    rd_out  <= rd;
                end
                case (op)
                    OP_RTYPE: begin
                        RegWrite <= 1'b1;
                        RegDst   <= 1'b1;
                        ALU_op   <= Instruction_in[3:0];
                    end
                    OP_ADDI: begin
                        RegWrite <= 1'b1;
                        ALUSrc   <= 1'b1;
                    end
                    OP_LW: begin
                        RegWrite <= 1'b1;
                        MemRead  <= 1'b1;
                        ALUSrc   <= 1'b1;
                    end
                    OP_SW: begin
                        MemWrite <= 1'b1;
                        ALUSrc   <= 1'b1;
                    end
                    OP_DSP: begin
                        DSP_sel  <= 1'b1;
                        RegWrite <= 1'b1;
                        RegDst   <= 1'b1;
                        ALU_op   <= Instruction_in[3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage2_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage2_decode
// Purpose  : Directed self-checking bench for stage2_decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage2_decode;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam logic [31:0] RTYPE   = 32'h00221804; // add-like r3 = r1 op r2, funct 4
    localparam logic [31:0] BEQ12   = 32'h10220005; // beq r1,r2,+5
    localparam logic [31:0] BEQ00   = 32'h10000005; // beq r0,r0,+5 (always equal)
    localparam logic [31:0] ADDI    = 32'h20220003; // addi r2,r1,3

    logic              clk = 1'b0;
    logic              reset;
    logic              En_Pipeline;
    logic [31:0]       Instruction_in;
    logic [ADDR_W-1:0] PC_in;
    logic              WB_en;
    logic [4:0]        WB_addr;
    logic [DATA_W-1:0] WB_data;
    logic              EX_MemRead;
    logic [4:0]        EX_rt;
    logic              Stall;
    logic              PC_sel;
    logic [ADDR_W-1:0] addr_BR_JMP;
    logic [DATA_W-1:0] RD1_out;
    logic [DATA_W-1:0] RD2_out;
    logic [DATA_W-1:0] Imm_out;
    logic [4:0]        rs_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;
    logic [3:0]        ALU_op;
    logic              RegWrite;
    logic              MemRead;
    logic              MemWrite;
    logic              ALUSrc;
    logic              RegDst;
    logic              DSP_sel;
    logic              Valid_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage2_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(32)) dut (
        .clk(clk), .reset(reset), .En_Pipeline(En_Pipeline),
        .Instruction_in(Instruction_in), .PC_in(PC_in),
        .WB_en(WB_en), .WB_addr(WB_addr), .WB_data(WB_data),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .Stall(Stall), .PC_sel(PC_sel), .addr_BR_JMP(addr_BR_JMP),
        .RD1_out(RD1_out), .RD2_out(RD2_out), .Imm_out(Imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .ALU_op(ALU_op),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .DSP_sel(DSP_sel), .Valid_out(Valid_out)
    );

    // {RegWrite, MemRead, MemWrite, ALUSrc, RegDst, DSP_sel, Valid_out}
    logic [6:0]   ctrl;
    logic [121:0] all_out;
    assign ctrl    = {RegWrite, MemRead, MemWrite, ALUSrc, RegDst, DSP_sel, Valid_out};
    assign all_out = {RD1_out, RD2_out, Imm_out, rs_out, rt_out, rd_out, ALU_op, ctrl};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        En_Pipeline = 1'b0;
        WB_en = 1'b1; WB_addr = a; WB_data = d;
        tick();
        WB_en = 1'b0; WB_addr = 5'd0; WB_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; En_Pipeline = 1'b1; Instruction_in = RTYPE; PC_in = '0;
        WB_en = 1'b1; WB_addr = 5'd1; WB_data = 32'h11111111;
        EX_MemRead = 1'b1; EX_rt = 5'd2;
        tick(); tick();
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
        Instruction_in = BEQ00; EX_MemRead = 1'b0; #1;
        checks++;
        if (PC_sel !== 1'b0) begin errors++; $display("FAIL reset_pcsel got %b want 0", PC_sel); end
        reset = 1'b1; WB_en = 1'b0; WB_addr = 5'd0; WB_data = '0; EX_rt = 5'd0;
        En_Pipeline = 1'b0;
    endtask

    task automatic test_rtype();
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        En_Pipeline = 1'b1; Instruction_in = RTYPE; PC_in = '0;
        tick();
        checks++;
        if (RD1_out !== 32'd5 || RD2_out !== 32'd7) begin
            errors++; $display("FAIL rtype_data got %0d/%0d want 5/7", RD1_out, RD2_out);
        end
        checks++;
        if ({rs_out, rt_out, rd_out} !== {5'd1, 5'd2, 5'd3}) begin
            errors++; $display("FAIL rtype_idx got %0d/%0d/%0d want 1/2/3", rs_out, rt_out, rd_out);
        end
        checks++;
        if (ALU_op !== 4'd4 || ctrl !== 7'b1000101 || Imm_out !== 32'h00001804) begin
            errors++; $display("FAIL rtype_ctrl got alu=%h ctrl=%b imm=%h want 4 1000101 00001804", ALU_op, ctrl, Imm_out);
        end
    endtask

    task automatic test_beq_taken();
        wb_write(5'd2, 32'd5);
        En_Pipeline = 1'b1; Instruction_in = BEQ12; PC_in = 12'd1; #1;
        checks++;
        if (PC_sel !== 1'b1 || addr_BR_JMP !== 12'd7) begin
            errors++; $display("FAIL beq_taken got sel=%b addr=%h want 1 007", PC_sel, addr_BR_JMP);
        end
        tick();
        checks++;
        if (Valid_out !== 1'b0) begin errors++; $display("FAIL beq_bubble got valid=%b want 0", Valid_out); end
        // Flush slot: hazard and branch must both be ignored.
        Instruction_in = RTYPE; EX_MemRead = 1'b1; EX_rt = 5'd2; #1;
        checks++;
        if (Stall !== 1'b0 || PC_sel !== 1'b0) begin
            errors++; $display("FAIL flush_no_stall got stall=%b sel=%b want 0 0", Stall, PC_sel);
        end
        tick();
        checks++;
        if (Valid_out !== 1'b0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL flush_squash got valid=%b rw=%b want 0 0", Valid_out, RegWrite);
        end
        EX_MemRead = 1'b0; EX_rt = 5'd0; Instruction_in = RTYPE;
        tick();
        checks++;
        if (Valid_out !== 1'b1 || RD2_out !== 32'd5) begin
            errors++; $display("FAIL flush_exit got valid=%b rd2=%0d want 1 5", Valid_out, RD2_out);
        end
    endtask

    task automatic test_branch_misc();
        // Not taken: r1=5, r2=9.
        wb_write(5'd2, 32'd9);
        En_Pipeline = 1'b1; Instruction_in = BEQ12; PC_in = 12'd1; #1;
        checks++;
        if (PC_sel !== 1'b0 || addr_BR_JMP !== 12'd0) begin
            errors++; $display("FAIL beq_not_taken got sel=%b addr=%h want 0 000", PC_sel, addr_BR_JMP);
        end
        tick();
        Instruction_in = RTYPE;
        tick();
        checks++;
        if (Valid_out !== 1'b1 || RD2_out !== 32'd9) begin
            errors++; $display("FAIL beq_nt_normal got valid=%b rd2=%0d want 1 9", Valid_out, RD2_out);
        end
        // Jump.
        Instruction_in = 32'h08000FFF; #1;
        checks++;
        if (PC_sel !== 1'b1 || addr_BR_JMP !== 12'hFFF) begin
            errors++; $display("FAIL jump got sel=%b addr=%h want 1 fff", PC_sel, addr_BR_JMP);
        end
        tick();
        Instruction_in = RTYPE;
        tick();
        checks++;
        if (Valid_out !== 1'b0) begin errors++; $display("FAIL jump_flush got valid=%b want 0", Valid_out); end
        // Target wrap.
        Instruction_in = 32'h10000001; PC_in = 12'hFFE; #1;
        checks++;
        if (PC_sel !== 1'b1 || addr_BR_JMP !== 12'h000) begin
            errors++; $display("FAIL beq_wrap got sel=%b addr=%h want 1 000", PC_sel, addr_BR_JMP);
        end
        tick();
        Instruction_in = RTYPE; PC_in = '0;
        tick();
    endtask

    task automatic test_decode_classes();
        logic [31:0] instr [6];
        logic [6:0]  exp_ctrl [6];
        logic [3:0]  exp_alu [6];
        logic [31:0] exp_imm [6];
        instr[0] = ADDI;          exp_ctrl[0] = 7'b1001001; exp_alu[0] = 4'h0; exp_imm[0] = 32'h00000003;
        instr[1] = 32'h8C22FFF0;  exp_ctrl[1] = 7'b1101001; exp_alu[1] = 4'h0; exp_imm[1] = 32'hFFFFFFF0;
        instr[2] = 32'hAC220004;  exp_ctrl[2] = 7'b0011001; exp_alu[2] = 4'h0; exp_imm[2] = 32'h00000004;
        instr[3] = 32'hFC221805;  exp_ctrl[3] = 7'b1000111; exp_alu[3] = 4'h5; exp_imm[3] = 32'h00001805;
        instr[4] = 32'h0C000005;  exp_ctrl[4] = 7'b0000001; exp_alu[4] = 4'h0; exp_imm[4] = 32'h00000000;
        instr[5] = 32'h0022180A;  exp_ctrl[5] = 7'b1000101; exp_alu[5] = 4'hA; exp_imm[5] = 32'h0000180A;
        En_Pipeline = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Instruction_in = instr[i];
            tick();
            checks++;
            if (ctrl !== exp_ctrl[i] || ALU_op !== exp_alu[i] || Imm_out !== exp_imm[i]) begin
                errors++;
                $display("FAIL decode_%0d got ctrl=%b alu=%h imm=%h want %b %h %h",
                         i, ctrl, ALU_op, Imm_out, exp_ctrl[i], exp_alu[i], exp_imm[i]);
            end
        end
    endtask

    task automatic test_hazard();
        En_Pipeline = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd2; Instruction_in = RTYPE; #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL hazard_rt got stall=%b want 1", Stall); end
        tick();
        checks++;
        if (Valid_out !== 1'b0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL hazard_bubble got valid=%b rw=%b want 0 0", Valid_out, RegWrite);
        end
        EX_rt = 5'd0; #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL hazard_r0 got stall=%b want 0", Stall); end
        tick();
        EX_rt = 5'd2; Instruction_in = ADDI; #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL hazard_addi_rt got stall=%b want 0", Stall); end
        tick();
        checks++;
        if (Valid_out !== 1'b1 || rt_out !== 5'd2) begin
            errors++; $display("FAIL hazard_addi_pass got valid=%b rt=%0d want 1 2", Valid_out, rt_out);
        end
        EX_rt = 5'd1; #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL hazard_rs got stall=%b want 1", Stall); end
        tick();
        EX_MemRead = 1'b0; EX_rt = 5'd0;
    endtask

    task automatic test_bypass();
        En_Pipeline = 1'b1; Instruction_in = RTYPE;
        WB_en = 1'b1; WB_addr = 5'd1; WB_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (RD1_out !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs got %h want deadbeef", RD1_out); end
        WB_addr = 5'd0; WB_data = 32'h12345678; Instruction_in = 32'h00001804;
        tick();
        checks++;
        if (RD1_out !== 32'd0 || RD2_out !== 32'd0) begin
            errors++; $display("FAIL bypass_r0 got %h/%h want 0/0", RD1_out, RD2_out);
        end
        WB_en = 1'b0; WB_data = '0;
        tick();
        checks++;
        if (RD1_out !== 32'd0) begin errors++; $display("FAIL r0_unwritten got %h want 0", RD1_out); end
    endtask

    task automatic test_hold();
        En_Pipeline = 1'b1; Instruction_in = RTYPE; PC_in = 12'd1;
        tick();
        En_Pipeline = 1'b0; Instruction_in = BEQ00;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (PC_sel !== 1'b0) begin errors++; $display("FAIL hold_pcsel_%0d got %b want 0", i, PC_sel); end
            tick();
            checks++;
            if (RD1_out !== 32'hDEADBEEF || RD2_out !== 32'd9 || Valid_out !== 1'b1) begin
                errors++; $display("FAIL hold_out_%0d got %h/%h v=%b want deadbeef/9 1", i, RD1_out, RD2_out, Valid_out);
            end
        end
        En_Pipeline = 1'b1; Instruction_in = BEQ00;
        tick();
        En_Pipeline = 1'b0; Instruction_in = RTYPE;
        repeat (4) tick();
        checks++;
        if (Valid_out !== 1'b0) begin errors++; $display("FAIL hold_flush_out got valid=%b want 0", Valid_out); end
        En_Pipeline = 1'b1;
        tick();
        checks++;
        if (Valid_out !== 1'b0) begin errors++; $display("FAIL hold_flush_state got valid=%b want 0", Valid_out); end
        tick();
        checks++;
        if (Valid_out !== 1'b1) begin errors++; $display("FAIL hold_flush_exit got valid=%b want 1", Valid_out); end
    endtask

    task automatic test_flush_reset();
        En_Pipeline = 1'b1; Instruction_in = BEQ00; PC_in = 12'd1;
        tick();
        #1;
        checks++;
        if (PC_sel !== 1'b0) begin errors++; $display("FAIL flush_beq got sel=%b want 0", PC_sel); end
        reset = 1'b0; EX_MemRead = 1'b1; EX_rt = 5'd1;
        tick();
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL flush_reset_out got %h want 0", all_out); end
        checks++;
        if (Stall !== 1'b0 || PC_sel !== 1'b0) begin
            errors++; $display("FAIL flush_reset_comb got stall=%b sel=%b want 0 0", Stall, PC_sel);
        end
        reset = 1'b1; EX_MemRead = 1'b0; EX_rt = 5'd0; Instruction_in = RTYPE;
        tick();
        checks++;
        if (Valid_out !== 1'b1 || RD1_out !== 32'd0 || RD2_out !== 32'd0) begin
            errors++; $display("FAIL post_reset got valid=%b rd1=%h rd2=%h want 1 0 0", Valid_out, RD1_out, RD2_out);
        end
    endtask

    initial begin
        reset = 1'b0; En_Pipeline = 1'b0; Instruction_in = '0; PC_in = '0;
        WB_en = 1'b0; WB_addr = '0; WB_data = '0; EX_MemRead = 1'b0; EX_rt = '0;
        test_reset();
        test_rtype();
        test_beq_taken();
        test_branch_misc();
        test_decode_classes();
        test_hazard();
        test_bypass();
        test_hold();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
